// File: rtl/blink_pkg.sv
// Shared types and constants for the blink rate controller.
// rate_t and RATE_MAX are used by the rate register; deb_state_t is used by the debounce FSM.
package blink_pkg;

    localparam int RATE_W = 2;

    typedef logic [RATE_W-1:0] rate_t;

    localparam rate_t RATE_MAX = rate_t'(3);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        PRESSED,
        WAIT_RELEASE
    } deb_state_t;

    // Step to the next rate index, wrapping from RATE_MAX back to 0.
    function automatic rate_t rate_next(input rate_t r);
        return (r == RATE_MAX) ? '0 : r + rate_t'(1);
    endfunction

    // Tick period for a rate index: each step up halves the period.
    function automatic int tick_limit(input int base, input rate_t r);
        return base >> r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button front end: a 2-flop synchroniser, then either a debounce FSM (BLINK_DEBOUNCE_EN defined)
// or a plain rising-edge detector. In both builds btn_evt is a registered one-cycle strobe per press.
module btn_debounce
    import blink_pkg::*;
#(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_evt
);

    // The edge that leaves IDLE already counts as the first stable cycle, so at least 2 are needed.
    if (DEB_CYCLES < 2) begin : g_deb_cycles_range
        $error("btn_debounce: DEB_CYCLES must be >= 2");
    end

    logic [1:0] sync_pipe;
    logic       btn_s;

    always_ff @(posedge clk) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[0], btn};
    end

    assign btn_s = sync_pipe[1];

`ifdef BLINK_DEBOUNCE_EN

    localparam int CNT_W = ($clog2(DEB_CYCLES) > 0) ? $clog2(DEB_CYCLES) : 1;
    // The counter reaches this value on the last required stable cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 2);

    deb_state_t       state;
    logic [CNT_W-1:0] stab_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            stab_cnt <= '0;
            btn_evt  <= 1'b0;
        end else begin
            btn_evt <= 1'b0;
            case (state)
                IDLE: begin
                    stab_cnt <= '0;
                    if (btn_s) state <= WAIT_PRESS;
                end
                WAIT_PRESS: begin
                    if (!btn_s) begin
                        state    <= IDLE;
                        stab_cnt <= '0;
                    end else if (stab_cnt == CNT_LAST) begin
                        state    <= PRESSED;
                        stab_cnt <= '0;
                        btn_evt  <= 1'b1;
                    end else begin
                        stab_cnt <= stab_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    stab_cnt <= '0;
                    if (!btn_s) state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (btn_s) begin
                        state    <= PRESSED;
                        stab_cnt <= '0;
                    end else if (stab_cnt == CNT_LAST) begin
                        state    <= IDLE;
                        stab_cnt <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    stab_cnt <= '0;
                end
            endcase
        end
    end

`else

    logic btn_s_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s_d <= 1'b0;
            btn_evt <= 1'b0;
        end else begin
            btn_s_d <= btn_s;
            btn_evt <= btn_s & ~btn_s_d;
        end
    end

`endif

endmodule

// File: rtl/blink_rate_ctrl.sv
// Blink tick generator whose period is selected by a button-stepped rate index (BASE_DIV >> rate).
// Button handling lives in btn_debounce; BLINK_DEBOUNCE_EN selects debounced or raw-edge presses.
module blink_rate_ctrl
    import blink_pkg::*;
#(
    parameter int BASE_DIV   = 12500000,
    parameter int DEB_CYCLES = 250000
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  btn,
    output logic  tick,
    output rate_t rate,
    output logic  btn_evt
);

    if (BASE_DIV < 8) begin : g_base_div_range
        $error("blink_rate_ctrl: BASE_DIV must be >= 8");
    end

    localparam int DIV_W = $clog2(BASE_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] lim_last;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .btn_evt (btn_evt)
    );

    always_comb begin
        lim_last = DIV_W'(tick_limit(BASE_DIV, rate) - 1);
    end

    // A rate change restarts the period and overrides a wrap landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate    <= '0;
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (btn_evt) begin
            rate    <= rate_next(rate);
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == lim_last) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            tick    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Self-checking bench for blink_rate_ctrl (BASE_DIV=16, DEB_CYCLES=4); follows BLINK_DEBOUNCE_EN.
// A behavioural model (press acceptance from run lengths, ticks from cycles-since-restart) runs alongside.
module tb_blink_rate_ctrl;

    localparam int BASE_DIV = 16;
    localparam int DEB      = 4;
`ifdef BLINK_DEBOUNCE_EN
    localparam int EVT_LAT  = 2 + DEB;   // edges from first sampling of btn=1 to btn_evt, inclusive
    localparam bit DEB_ON   = 1'b1;
`else
    localparam int EVT_LAT  = 3;
    localparam bit DEB_ON   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       tick;
    logic [1:0] rate;
    logic       btn_evt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    logic m_tick = 1'b0;
    logic m_evt  = 1'b0;
    int   m_rate = 0;
    int   m_age  = 0;
    logic bq[$];
`ifdef BLINK_DEBOUNCE_EN
    logic m_lvl     = 1'b0;
    logic m_run_val = 1'b0;
    int   m_run_len = 0;
`else
    logic m_prev_s2 = 1'b0;
`endif

    blink_rate_ctrl #(
        .BASE_DIV   (BASE_DIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .tick    (tick),
        .rate    (rate),
        .btn_evt (btn_evt)
    );

    always #20 clk = ~clk;

    // Drive one edge's inputs, advance the model over that edge, return at the following negedge.
    task automatic step(input logic b, input logic r);
        logic s2;
        logic new_evt;
        int   lim;
        btn = b;
        rst = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_tick = 1'b0;
            m_evt  = 1'b0;
            m_rate = 0;
            m_age  = 0;
            bq.delete();
`ifdef BLINK_DEBOUNCE_EN
            m_lvl     = 1'b0;
            m_run_val = 1'b0;
            m_run_len = 0;
`else
            m_prev_s2 = 1'b0;
`endif
        end else begin
            // the level seen by the press logic is btn as sampled two edges ago
            s2 = (bq.size() >= 2) ? bq[bq.size()-2] : 1'b0;
            bq.push_back(b);
            if (bq.size() > 2) void'(bq.pop_front());
`ifdef BLINK_DEBOUNCE_EN
            if (m_run_len > 0 && s2 == m_run_val) m_run_len++;
            else begin
                m_run_val = s2;
                m_run_len = 1;
            end
            new_evt = 1'b0;
            if (m_run_len >= DEB && m_run_val != m_lvl) begin
                m_lvl   = m_run_val;
                new_evt = m_lvl;
            end
`else
            new_evt   = s2 & ~m_prev_s2;
            m_prev_s2 = s2;
`endif
            if (m_evt) begin
                m_rate = (m_rate + 1) % 4;
                m_age  = 0;
                m_tick = 1'b0;
            end else begin
                m_age++;
                lim    = BASE_DIV >> m_rate;
                m_tick = (m_age % lim) == 0;
            end
            m_evt = new_evt;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [1:0] mr;
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom_range(0, 1)), 1'b1);
            n_checks++;
            if ({tick, rate, btn_evt} !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got tick=%b rate=%0d evt=%b want all 0",
                         cyc, tick, rate, btn_evt);
            end
        end
        step(1'b0, 1'b1);
        mr = m_rate[1:0];
        n_checks++;
        if ({tick, rate, btn_evt} !== {m_tick, mr, m_evt}) begin
            n_fail++;
            $display("FAIL reset_model cyc=%0d got %b%0d%b want %b%0d%b",
                     cyc, tick, rate, btn_evt, m_tick, mr, m_evt);
        end
    endtask

    task automatic test_idle_tick();
        int first = -1;
        int ticks = 0;
        int evts  = 0;
        logic [1:0] mr;
        step(1'b0, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            step(1'b0, 1'b0);
            mr = m_rate[1:0];
            n_checks++;
            if ({tick, rate, btn_evt} !== {m_tick, mr, m_evt}) begin
                n_fail++;
                $display("FAIL idle_model k=%0d got tick=%b rate=%0d evt=%b want tick=%b rate=%0d evt=%b",
                         k, tick, rate, btn_evt, m_tick, mr, m_evt);
            end
            if (tick === 1'b1) begin
                ticks++;
                if (first < 0) first = k;
            end
            if (btn_evt !== 1'b0) evts++;
        end
        n_checks++;
        if (first != BASE_DIV) begin
            n_fail++;
            $display("FAIL idle_first_tick got edge %0d want %0d", first, BASE_DIV);
        end
        n_checks++;
        if (ticks != 3 || evts != 0) begin
            n_fail++;
            $display("FAIL idle_counts got ticks=%0d evts=%0d want ticks=3 evts=0", ticks, evts);
        end
    endtask

    task automatic test_single_press();
        int t_evt = -1;
        int evts  = 0;
        int tq[$];
        logic [1:0] mr;
        step(1'b0, 1'b1);
        for (int k = 1; k <= 60; k++) begin
            step(k <= 20, 1'b0);
            mr = m_rate[1:0];
            n_checks++;
            if ({tick, rate, btn_evt} !== {m_tick, mr, m_evt}) begin
                n_fail++;
                $display("FAIL press_model k=%0d got tick=%b rate=%0d evt=%b want tick=%b rate=%0d evt=%b",
                         k, tick, rate, btn_evt, m_tick, mr, m_evt);
            end
            if (btn_evt === 1'b1) begin
                evts++;
                if (t_evt < 0) t_evt = k;
            end
            if (tick === 1'b1 && t_evt > 0) tq.push_back(k);
        end
        n_checks++;
        if (evts != 1 || t_evt != EVT_LAT) begin
            n_fail++;
            $display("FAIL press_evt got count=%0d at edge %0d want 1 at edge %0d", evts, t_evt, EVT_LAT);
        end
        n_checks++;
        if (rate !== 2'd1) begin
            n_fail++;
            $display("FAIL press_rate got %0d want 1", rate);
        end
        n_checks++;
        if (tq.size() < 2 || tq[0] != t_evt + 1 + 8 || tq[1] - tq[0] != 8) begin
            n_fail++;
            $display("FAIL press_period got %0d ticks first=%0d want first=%0d period 8",
                     tq.size(), (tq.size() > 0) ? tq[0] : -1, t_evt + 9);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] pat = 8'b0011_0011;   // read LSB first: 1,1,0,0,1,1,0,0
        int evts = 0;
        logic [1:0] mr;
        step(1'b0, 1'b1);
        for (int k = 0; k < 24; k++) begin
            step((k < 8) ? pat[k] : 1'b0, 1'b0);
            mr = m_rate[1:0];
            n_checks++;
            if ({tick, rate, btn_evt} !== {m_tick, mr, m_evt}) begin
                n_fail++;
                $display("FAIL glitch_model k=%0d got tick=%b rate=%0d evt=%b want tick=%b rate=%0d evt=%b",
                         k, tick, rate, btn_evt, m_tick, mr, m_evt);
            end
            if (btn_evt === 1'b1) evts++;
        end
        n_checks++;
        if (evts != (DEB_ON ? 0 : 2) || rate !== (DEB_ON ? 2'd0 : 2'd2)) begin
            n_fail++;
            $display("FAIL glitch_filter got evts=%0d rate=%0d want evts=%0d rate=%0d",
                     evts, rate, DEB_ON ? 0 : 2, DEB_ON ? 0 : 2);
        end
    endtask

    task automatic test_rate_wrap();
        int per;
        int t_upd;
        int tq[$];
        logic [1:0] mr;
        step(1'b0, 1'b1);
        for (int p = 0; p < 4; p++) begin
            per   = BASE_DIV >> ((p + 1) % 4);
            t_upd = -1;
            tq.delete();
            for (int k = 1; k <= 40; k++) begin
                step(k <= 8, 1'b0);
                mr = m_rate[1:0];
                n_checks++;
                if ({tick, rate, btn_evt} !== {m_tick, mr, m_evt}) begin
                    n_fail++;
                    $display("FAIL wrap_model p=%0d k=%0d got tick=%b rate=%0d evt=%b want tick=%b rate=%0d evt=%b",
                             p, k, tick, rate, btn_evt, m_tick, mr, m_evt);
                end
                if (btn_evt === 1'b1 && t_upd < 0) t_upd = k + 1;
                if (tick === 1'b1 && t_upd > 0 && k >= t_upd) tq.push_back(k);
            end
            n_checks++;
            if (rate !== 2'((p + 1) % 4)) begin
                n_fail++;
                $display("FAIL wrap_rate p=%0d got %0d want %0d", p, rate, (p + 1) % 4);
            end
            n_checks++;
            if (tq.size() < 2 || tq[0] - t_upd != per || tq[1] - tq[0] != per) begin
                n_fail++;
                $display("FAIL wrap_period p=%0d got %0d ticks first gap=%0d want period %0d",
                         p, tq.size(), (tq.size() > 0) ? tq[0] - t_upd : -1, per);
            end
        end
    endtask

    task automatic test_collision();
        int s = BASE_DIV - EVT_LAT;   // first sampling edge so btn_evt lands with counter at 15
        int next_tick = -1;
        step(1'b0, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            step(k >= s, 1'b0);
            if (k == BASE_DIV - 1) begin
                n_checks++;
                if (btn_evt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL collide_evt got %b want 1 at edge %0d", btn_evt, k);
                end
            end
            if (k == BASE_DIV) begin
                n_checks++;
                if (tick !== 1'b0 || rate !== 2'd1) begin
                    n_fail++;
                    $display("FAIL collide_update got tick=%b rate=%0d want tick=0 rate=1", tick, rate);
                end
            end
            if (k > BASE_DIV && tick === 1'b1 && next_tick < 0) next_tick = k;
        end
        n_checks++;
        if (next_tick != BASE_DIV + 8) begin
            n_fail++;
            $display("FAIL collide_next_tick got edge %0d want %0d", next_tick, BASE_DIV + 8);
        end
    endtask

    task automatic test_reset_mid();
        int t_evt = -1;
        int evts  = 0;
        logic [1:0] mr;
        step(1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) step(k >= 9, 1'b0);
        n_checks++;
        if (m_age != 10) begin
            n_fail++;
            $display("FAIL midrst_setup model age=%0d want 10", m_age);
        end
        step(1'b1, 1'b1);
        n_checks++;
        if ({tick, rate, btn_evt} !== 4'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs got tick=%b rate=%0d evt=%b want all 0", tick, rate, btn_evt);
        end
        for (int j = 1; j <= 20; j++) begin
            step(1'b1, 1'b0);
            mr = m_rate[1:0];
            n_checks++;
            if ({tick, rate, btn_evt} !== {m_tick, mr, m_evt}) begin
                n_fail++;
                $display("FAIL midrst_model j=%0d got tick=%b rate=%0d evt=%b want tick=%b rate=%0d evt=%b",
                         j, tick, rate, btn_evt, m_tick, mr, m_evt);
            end
            if (btn_evt === 1'b1) begin
                evts++;
                if (t_evt < 0) t_evt = j;
            end
        end
        n_checks++;
        if (evts != 1 || t_evt != EVT_LAT || rate !== 2'd1) begin
            n_fail++;
            $display("FAIL midrst_requal got evts=%0d at %0d rate=%0d want 1 at %0d rate=1",
                     evts, t_evt, rate, EVT_LAT);
        end
    endtask

    task automatic test_random();
        logic b = 1'b0;
        int   run = 0;
        logic r;
        logic [1:0] mr;
        for (int k = 0; k < 800; k++) begin
            if (run == 0) begin
                b   = ~b;
                run = $urandom_range(1, 12);
            end
            run--;
            r = ($urandom_range(0, 79) == 0);
            step(b, r);
            mr = m_rate[1:0];
            n_checks++;
            if ({tick, rate, btn_evt} !== {m_tick, mr, m_evt}) begin
                n_fail++;
                $display("FAIL random_model k=%0d got tick=%b rate=%0d evt=%b want tick=%b rate=%0d evt=%b",
                         k, tick, rate, btn_evt, m_tick, mr, m_evt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_tick();
        test_single_press();
        test_glitch();
        test_rate_wrap();
        test_collision();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
